// File: rtl/miriscv_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_lsu_pkg
// Brief   : Load/store size codes and byte-lane helpers shared by the LSU.
// Revision: 1.0 - initial release
// ============================================================================
package miriscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    function automatic logic lsu_size_ok(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: return 1'b1;
            LDST_H, LDST_HU: return ~off[0];
            LDST_W:          return (off == 2'b00);
            default:         return 1'b0;
        endcase
    endfunction

    // Width code is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] lsu_be(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [1:0] width, input logic [31:0] d);
        case (width)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_lsu_ext.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_lsu_ext
// Brief   : Selects the addressed lane of read data and sign/zero-extends it.
// Revision: 1.0 - initial release
// ============================================================================
module miriscv_lsu_ext (
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_size,
    output logic [31:0] o_data
);
    import miriscv_lsu_pkg::*;

    logic [31:0] w_shifted;

    // Halfword offsets are always even, so one byte-granular shift serves both.
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            LDST_B:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LDST_BU: o_data = {24'd0, w_shifted[7:0]};
            LDST_H:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LDST_HU: o_data = {16'd0, w_shifted[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/miriscv_lsu.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_lsu
// Brief   : Load/store unit driving the req/gnt/rvalid data-memory bus.
// Revision: 1.0 - initial release
// ============================================================================
module miriscv_lsu #(
    parameter int RESP_TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic        lsu_fault_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);
    import miriscv_lsu_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_GNT    = 2'd1,
        S_WAIT_RVALID = 2'd2
    } state_t;

    localparam int c_CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((RESP_TIMEOUT > 0) ? (RESP_TIMEOUT - 1) : 0);

    state_t              r_state;
    logic                r_we;
    logic [2:0]          r_size;
    logic [1:0]          r_off;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic [29:0]         r_waddr;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_idle_req;
    logic                w_legal;
    logic                w_accept;
    logic                w_misalign;
    logic                w_complete;
    logic                w_fault;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [31:0]         w_ext;

    assign w_legal    = lsu_size_ok(lsu_size_i, lsu_addr_i[1:0]);
    assign w_be       = lsu_be(lsu_size_i[1:0], lsu_addr_i[1:0]);
    assign w_wdata    = lsu_wdata(lsu_size_i[1:0], lsu_data_i);
    // Gating with rst_i keeps every output at zero while reset is held.
    assign w_idle_req = ~rst_i & lsu_req_i & (r_state == S_IDLE);
    assign w_accept   = w_idle_req & w_legal;
    assign w_misalign = w_idle_req & ~w_legal;
    assign w_complete = (r_state == S_WAIT_RVALID) & data_rvalid_i;
    assign w_fault    = (RESP_TIMEOUT > 0) & (r_state == S_WAIT_RVALID) &
                        ~data_rvalid_i & (r_cnt == c_CNT_LAST);

    assign lsu_misalign_o  = w_misalign;
    assign lsu_fault_o     = w_fault;
    assign lsu_stall_req_o = ~rst_i & lsu_req_i & ~w_complete & ~w_misalign & ~w_fault;

    miriscv_lsu_ext u_ext (
        .i_rdata  (data_rdata_i),
        .i_offset (r_off),
        .i_size   (r_size),
        .o_data   (w_ext)
    );

    assign lsu_data_o = (w_complete & ~r_we) ? w_ext : 32'd0;

    // First request cycle is driven straight from the operands; retries replay the latched copy.
    always_comb begin
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = 4'd0;
        data_addr_o  = 32'd0;
        data_wdata_o = 32'd0;
        if (w_accept) begin
            data_req_o   = 1'b1;
            data_we_o    = lsu_we_i;
            data_be_o    = w_be;
            data_addr_o  = {lsu_addr_i[31:2], 2'b00};
            data_wdata_o = w_wdata;
        end else if (r_state == S_WAIT_GNT) begin
            data_req_o   = 1'b1;
            data_we_o    = r_we;
            data_be_o    = r_be;
            data_addr_o  = {r_waddr, 2'b00};
            data_wdata_o = r_wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_waddr <= 30'd0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= lsu_we_i;
                        r_size  <= lsu_size_i;
                        r_off   <= lsu_addr_i[1:0];
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_waddr <= lsu_addr_i[31:2];
                        r_cnt   <= '0;
                        r_state <= data_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
                    end
                end
                S_WAIT_GNT: begin
                    if (data_gnt_i) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_RVALID;
                    end
                end
                S_WAIT_RVALID: begin
                    if (w_complete || w_fault) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miriscv_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_miriscv_lsu
// Brief   : Directed scoreboard bench for the load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_miriscv_lsu;

    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_MIS  = 2'd2;
    localparam logic [1:0] K_FLT  = 2'd3;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = 3'd0;
    logic [31:0] lsu_addr_i = 32'd0;
    logic [31:0] lsu_data_i = 32'd0;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_misalign_o;
    logic        lsu_fault_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    bus_t bus_q[$];
    rsp_t rsp_q[$];

    miriscv_lsu #(.RESP_TIMEOUT(4)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_misalign_o  (lsu_misalign_o),
        .lsu_fault_o     (lsu_fault_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (lsu_stall_req_o) stall_cnt++;
            if (data_req_o) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected_req", 128'(data_req_o), 128'(0));
                end else begin
                    check("bus_fields", 128'({data_we_o, data_be_o, data_addr_o, data_wdata_o}),
                          128'(bus_q[0]));
                    if (data_gnt_i) void'(bus_q.pop_front());
                end
            end
            if (lsu_misalign_o || lsu_fault_o || (lsu_req_i && !lsu_stall_req_o)) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 128'({lsu_misalign_o, lsu_fault_o, lsu_data_o}), 128'(0));
                end else begin
                    check("rsp_kind_data",
                          128'({lsu_misalign_o ? K_MIS : (lsu_fault_o ? K_FLT : K_DONE), lsu_data_o}),
                          128'(rsp_q[0]));
                    check("rsp_stall_low", 128'(lsu_stall_req_o), 128'(0));
                    void'(rsp_q.pop_front());
                end
            end else if (lsu_data_o != 32'd0) begin
                check("data_idle_zero", 128'(lsu_data_o), 128'(0));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] d, input logic [31:0] rdata, input int gnt_dly,
                              input bit with_gnt, input bit give_rv, input int exp_stall,
                              input string name);
        stall_cnt  = 0;
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = d;
        data_gnt_i = with_gnt && (gnt_dly == 0);
        if (with_gnt) begin
            for (int i = 0; i < gnt_dly; i++) begin
                @(posedge clk_i); #1;
                data_gnt_i = (i == gnt_dly - 1);
            end
            @(posedge clk_i); #1;
            data_gnt_i = 1'b0;
            if (give_rv) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = rdata;
            end
        end
        for (int i = 0; i < 20 && rsp_q.size() != 0; i++) begin
            @(posedge clk_i); #1;
            data_rvalid_i = 1'b0;
        end
        if (rsp_q.size() != 0) begin
            check({name, "_timeout"}, 128'(rsp_q.size()), 128'(0));
            rsp_q.delete();
            bus_q.delete();
        end
        lsu_req_i     = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'd0;
        check({name, "_stall_cycles"}, 128'(stall_cnt), 128'(exp_stall));
        check({name, "_bus_drained"}, 128'(bus_q.size()), 128'(0));
        @(posedge clk_i); #1;
    endtask

    initial begin
        @(negedge clk_i);
        check("reset_outputs", 128'({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
                                     lsu_stall_req_o, lsu_misalign_o, lsu_fault_o, lsu_data_o}), 128'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // SW 0x100: word lanes, single-cycle grant
        bus_q.push_back('{1'b1, 4'b1111, 32'h100, 32'hDEADBEEF});
        rsp_q.push_back('{K_DONE, 32'h0});
        run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b1, 1'b1, 1, "sw");

        // SB 0x103: top lane, replicated byte
        bus_q.push_back('{1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5});
        rsp_q.push_back('{K_DONE, 32'h0});
        run_access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 1'b1, 1'b1, 1, "sb");

        // SH 0x102: upper half lanes, replicated half
        bus_q.push_back('{1'b1, 4'b1100, 32'h100, 32'hBEEFBEEF});
        rsp_q.push_back('{K_DONE, 32'h0});
        run_access(1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 0, 1'b1, 1'b1, 1, "sh");

        // LB / LBU / LHU / LH at 0x102
        bus_q.push_back('{1'b0, 4'b0100, 32'h100, 32'h0});
        rsp_q.push_back('{K_DONE, 32'hFFFFFF80});
        run_access(1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 0, 1'b1, 1'b1, 1, "lb");

        bus_q.push_back('{1'b0, 4'b0100, 32'h100, 32'h0});
        rsp_q.push_back('{K_DONE, 32'h00000080});
        run_access(1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 0, 1'b1, 1'b1, 1, "lbu");

        bus_q.push_back('{1'b0, 4'b1100, 32'h100, 32'h0});
        rsp_q.push_back('{K_DONE, 32'h00000080});
        run_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h0080FF00, 0, 1'b1, 1'b1, 1, "lhu");

        bus_q.push_back('{1'b0, 4'b1100, 32'h100, 32'h0});
        rsp_q.push_back('{K_DONE, 32'hFFFF8001});
        run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 1'b1, 1'b1, 1, "lh");

        // Grant held off three cycles: request held four cycles, stall until rvalid
        bus_q.push_back('{1'b1, 4'b1111, 32'h10C, 32'hCAFEF00D});
        rsp_q.push_back('{K_DONE, 32'h0});
        run_access(1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0, 3, 1'b1, 1'b1, 4, "sw_gnt3");

        bus_q.push_back('{1'b0, 4'b1111, 32'h104, 32'h0});
        rsp_q.push_back('{K_DONE, 32'h12345678});
        run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 3, 1'b1, 1'b1, 4, "lw_gnt3");

        // Misaligned and illegal-size requests: pulse, no bus request
        rsp_q.push_back('{K_MIS, 32'h0});
        run_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b0, 1'b0, 0, "lw_mis");
        rsp_q.push_back('{K_MIS, 32'h0});
        run_access(1'b1, 3'b001, 32'h101, 32'h1111, 32'h0, 0, 1'b0, 1'b0, 0, "sh_mis");
        rsp_q.push_back('{K_MIS, 32'h0});
        run_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0, 1'b0, 0, "size011");

        // Reset while waiting for rvalid, then a late rvalid in IDLE
        bus_q.push_back('{1'b0, 4'b1111, 32'h300, 32'h0});
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'b010;
        lsu_addr_i = 32'h300;
        lsu_data_i = 32'h0;
        data_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        data_gnt_i = 1'b0;
        rst_i      = 1'b1;
        @(negedge clk_i);
        check("midreset_outputs", 128'({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
                                        lsu_stall_req_o, lsu_misalign_o, lsu_fault_o, lsu_data_o}), 128'(0));
        @(posedge clk_i); #1;
        rst_i         = 1'b0;
        lsu_req_i     = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFFFFFF;
        @(negedge clk_i);
        check("late_rvalid_ignored", 128'({data_req_o, lsu_stall_req_o, lsu_fault_o, lsu_data_o}), 128'(0));
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        check("midreset_bus_drained", 128'(bus_q.size()), 128'(0));
        bus_q.delete();

        // Access after reset recovery: LBU at offset 1
        bus_q.push_back('{1'b0, 4'b0010, 32'h0, 32'h0});
        rsp_q.push_back('{K_DONE, 32'h0000007F});
        run_access(1'b0, 3'b100, 32'h001, 32'h0, 32'h00007F00, 0, 1'b1, 1'b1, 1, "lbu_after_rst");

        // Response timeout: no rvalid, fault on the fourth waiting cycle
        bus_q.push_back('{1'b0, 4'b1111, 32'h200, 32'h0});
        rsp_q.push_back('{K_FLT, 32'h0});
        run_access(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 0, 1'b1, 1'b0, 4, "timeout");

        // Normal access still works after a fault
        bus_q.push_back('{1'b0, 4'b0011, 32'h200, 32'h0});
        rsp_q.push_back('{K_DONE, 32'hFFFF8765});
        run_access(1'b0, 3'b001, 32'h200, 32'h0, 32'h00008765, 1, 1'b1, 1'b1, 2, "lh_after_fault");

        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
